// File: rtl/down_counter_mux.sv
// Two-digit down counter with runtime hex/BCD mode, synchronous load, wrap/hold at
// zero, a prescaled step rate and a registered terminal-count pulse.
module down_counter_mux #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned TICK_W   = 27
) (
  input  logic       dcm_clk,
  input  logic       dcm_rst,
  input  logic       dcm_en,
  input  logic       dcm_sel,
  input  logic       dcm_load,
  input  logic [7:0] dcm_load_val,
  input  logic       dcm_wrap,
  output logic [7:0] dcm_out,
  output logic       dcm_zero,
  output logic       dcm_tc
);

  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

  logic [7:0]        out_q, out_d;
  logic              zero_q;
  logic              tc_q, tc_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              sel_q;
  logic              init_q;
  logic              mode_chg;
  logic              step;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] mode_max(input logic bcd);
    return bcd ? 8'h99 : 8'hFF;
  endfunction

  // Caller guarantees v != 0; out-of-range digits are pinned to 9 before the borrow.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = clamp_digit(v[7:4]);
    lo = clamp_digit(v[3:0]);
    if (lo != 4'd0) return {hi, lo - 4'd1};
    else            return {hi - 4'd1, 4'd9};
  endfunction

  // sel_q cannot capture dcm_sel asynchronously, so the first edge after reset
  // release is never treated as a mode change; this makes sel_q track the
  // select value present at release.
  assign mode_chg = init_q && (dcm_sel != sel_q);
  assign step     = dcm_en && (presc_q == PRESC_LAST);

  always_comb begin
    out_d   = out_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    if (dcm_load) begin
      out_d   = dcm_sel ? {clamp_digit(dcm_load_val[7:4]), clamp_digit(dcm_load_val[3:0])}
                        : dcm_load_val;
      presc_d = '0;
    end else if (mode_chg) begin
      out_d   = mode_max(dcm_sel);
      presc_d = '0;
    end else if (step) begin
      presc_d = '0;
      if (out_q == 8'h00) begin
        out_d = dcm_wrap ? mode_max(dcm_sel) : 8'h00;
      end else begin
        out_d = dcm_sel ? bcd_dec(out_q) : out_q - 8'h01;
        tc_d  = (out_d == 8'h00);
      end
    end else if (dcm_en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge dcm_clk or negedge dcm_rst) begin
    if (!dcm_rst) begin
      out_q   <= '0;
      zero_q  <= 1'b1;
      tc_q    <= 1'b0;
      presc_q <= '0;
      sel_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= (out_d == 8'h00);
      tc_q    <= tc_d;
      presc_q <= presc_d;
      sel_q   <= dcm_sel;
      init_q  <= 1'b1;
    end
  end

  assign dcm_out  = out_q;
  assign dcm_zero = zero_q;
  assign dcm_tc   = tc_q;

endmodule
